// File: rtl/ad_ip_jesd204_tpl_dac_dma_fifo_pkg.sv
// Shared definitions for the TPL DAC DMA FIFO slice: FSM state encoding.
// Encodings are fixed so register dumps read the same across the TPL blocks.
package ad_ip_jesd204_tpl_dac_dma_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_fifo_mem.sv
// Simple dual-port sample RAM, DEPTH x DATA_WIDTH; write lands at the clock edge.
// Read data is registered (1 cycle) and holds between reads; clear_i forces it to zero.
module ad_ip_jesd204_tpl_dac_fifo_mem #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic                  clear_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Storage has no reset; only the output register is architecturally visible.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (clear_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_dma_fifo.sv
// Elastic DMA-to-TPL sample buffer with prefill gate and underflow flag, link_clk only.
// Read latency 1 cycle per dac_valid; s_ready drops when full or idle (registered level only).
module ad_ip_jesd204_tpl_dac_dma_fifo
    import ad_ip_jesd204_tpl_dac_dma_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 6,
    parameter int PREFILL    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  dac_valid,
    output logic [DATA_WIDTH-1:0] dac_ddata,
    output logic                  dac_dunf,
    output logic [ADDR_WIDTH:0]   level
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   PREFILL_L = (ADDR_WIDTH+1)'(PREFILL);
    localparam logic [ADDR_WIDTH:0]   LVL_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    fifo_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]     level_q, level_d;
    logic                    dunf_q, dunf_d;

    logic wr_en;
    logic rd_req;
    logic rd_en;
    logic underflow;
    logic rd_clear;

    // Readiness looks only at registered state, so a full FIFO rejects even on a same-cycle read.
    assign s_ready   = (level_q != DEPTH_L) && (state_q != ST_IDLE);
    assign wr_en     = s_valid && s_ready;

    assign rd_req    = dac_valid && enable && (state_q == ST_RUN);
    assign rd_en     = rd_req && (level_q != '0);
    assign underflow = rd_req && (level_q == '0);

    // Output register reads as zero outside RUN, on flush/reset and on an underflowed strobe.
    assign rd_clear  = rst || !enable || (state_q != ST_RUN) || underflow;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        dunf_d   = underflow;

        if (!enable) begin
            state_d  = ST_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            dunf_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE:    state_d = ST_PREFILL;
                ST_PREFILL: if (level_q >= PREFILL_L) state_d = ST_RUN;
                ST_RUN:     state_d = ST_RUN;
                default:    state_d = ST_IDLE;
            endcase

            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end

            unique case ({wr_en, rd_en})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dunf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dunf_q   <= dunf_d;
        end
    end

    ad_ip_jesd204_tpl_dac_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_en && enable && !rst),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (s_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q),
        .clear_i   (rd_clear),
        .rd_data_o (dac_ddata)
    );

    assign dac_dunf = dunf_q;
    assign level    = level_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_dma_fifo.sv
// Bench for the TPL DAC DMA FIFO: queue-based reference model plus per-cycle scoreboard.
module tb_ad_ip_jesd204_tpl_dac_dma_fifo;

    localparam int DW      = 128;
    localparam int AW      = 6;
    localparam int DEPTH   = 2 ** AW;
    localparam int PREFILL = 16;

    typedef struct packed {
        logic [DW-1:0] dd;
        logic          dunf;
    } exp_t;

    typedef enum int {M_IDLE, M_PREFILL, M_RUN} mstate_e;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          dac_valid;
    logic [DW-1:0] dac_ddata;
    logic          dac_dunf;
    logic [AW:0]   level;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] m_fifo[$];
    exp_t          sb_q[$];
    mstate_e       m_state  = M_IDLE;
    logic [DW-1:0] m_dd     = '0;
    logic          last_acc = 1'b0;

    ad_ip_jesd204_tpl_dac_dma_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .PREFILL    (PREFILL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .dac_valid (dac_valid),
        .dac_ddata (dac_ddata),
        .dac_dunf  (dac_dunf),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat(input int t);
        logic [31:0] u;
        u = 32'(t);
        return {32'hD000_0000 | u, 32'hC000_0000 | u, 32'hB000_0000 | u, 32'hA000_0000 | u};
    endfunction

    // One link_clk cycle: drive after negedge, predict, check outputs #1 after posedge.
    task automatic step(input logic r, input logic en, input logic sv,
                        input logic [DW-1:0] sd, input logic dv);
        exp_t e;
        logic rdy_exp;
        logic acc;
        rst       = r;
        enable    = en;
        s_valid   = sv;
        s_data    = sd;
        dac_valid = dv;
        #1;
        rdy_exp = (m_state != M_IDLE) && (m_fifo.size() != DEPTH);
        chk("s_ready", DW'(s_ready), DW'(rdy_exp));
        acc      = sv && rdy_exp;
        last_acc = acc;
        e.dunf   = 1'b0;
        if (r || !en) begin
            m_fifo.delete();
            m_state = M_IDLE;
            m_dd    = '0;
        end else begin
            case (m_state)
                M_IDLE: m_state = M_PREFILL;
                M_PREFILL: begin
                    m_dd = '0;
                    if (m_fifo.size() >= PREFILL) m_state = M_RUN;
                    if (acc) m_fifo.push_back(sd);
                end
                default: begin
                    if (dv) begin
                        if (m_fifo.size() == 0) begin
                            m_dd   = '0;
                            e.dunf = 1'b1;
                        end else begin
                            m_dd = m_fifo.pop_front();
                        end
                    end
                    if (acc) m_fifo.push_back(sd);
                end
            endcase
        end
        e.dd = m_dd;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("dac_ddata", dac_ddata, e.dd);
        chk("dac_dunf", DW'(dac_dunf), DW'(e.dunf));
        chk("level", DW'(level), DW'(m_fifo.size()));
        @(negedge clk);
    endtask

    task automatic push_n(input int base, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, beat(base + i), 1'b0);
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        dac_valid = 1'b0;
        @(negedge clk);

        // Reset state
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("rst_s_ready", DW'(s_ready), '0);
        chk("rst_ddata", dac_ddata, '0);
        chk("rst_dunf", DW'(dac_dunf), '0);
        chk("rst_level", DW'(level), '0);

        // 1: prefill gate, 15 beats then a strobe reads zero; 16th beat opens RUN
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        push_n(100, 15);
        read_n(1);
        push_n(115, 1);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        read_n(1);
        chk("t1_first_beat", dac_ddata, beat(100));

        // 2: drain to one beat, then beat + single-cycle underflow
        read_n(14);
        chk("t2_level_one", DW'(level), DW'(1));
        read_n(2);
        chk("t2_unf_data", dac_ddata, '0);
        chk("t2_unf_flag", DW'(dac_dunf), DW'(1));
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("t2_unf_one_cycle", DW'(dac_dunf), '0);

        // 3: full FIFO, write+read same cycle loses the write
        push_n(200, DEPTH);
        chk("t3_full_level", DW'(level), DW'(DEPTH));
        chk("t3_full_ready", DW'(s_ready), '0);
        step(1'b0, 1'b1, 1'b1, beat(999), 1'b1);
        chk("t3_level_63", DW'(level), DW'(DEPTH - 1));
        read_n(DEPTH - 1);
        chk("t3_drained", DW'(level), '0);

        // 4: 200 incrementing beats under random stalls and strobes
        begin
            int   wr_i;
            int   cyc;
            logic sv;
            logic dv;
            wr_i = 0;
            cyc  = 0;
            sv   = 1'b0;
            while ((wr_i < 200 || m_fifo.size() != 0) && cyc < 4000) begin
                if (!(sv && !last_acc)) sv = (wr_i < 200) && ($urandom_range(0, 3) != 0);
                dv = (m_fifo.size() > 0) && ($urandom_range(0, 2) != 0);
                step(1'b0, 1'b1, sv, beat(1000 + wr_i), dv);
                if (last_acc) wr_i++;
                cyc++;
            end
            chk("t4_completed", DW'(cyc < 4000), DW'(1));
            chk("t4_last_beat", dac_ddata, beat(1199));
        end

        // 5: drop enable mid-RUN at level 20, then prefill again
        push_n(3000, 21);
        read_n(1);
        chk("t5_level_20", DW'(level), DW'(20));
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("t5_flush_level", DW'(level), '0);
        chk("t5_flush_ready", DW'(s_ready), '0);
        chk("t5_flush_ddata", dac_ddata, '0);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        push_n(4000, 1);
        read_n(1);
        chk("t5_prefill_again", dac_ddata, '0);
        push_n(4001, 15);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        read_n(1);
        chk("t5_resume_beat", dac_ddata, beat(4000));

        // 6: reset mid-RUN with write and read pending
        step(1'b1, 1'b1, 1'b1, beat(777), 1'b1);
        chk("t6_level", DW'(level), '0);
        chk("t6_ddata", dac_ddata, '0);
        chk("t6_dunf", DW'(dac_dunf), '0);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        push_n(800, 16);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        read_n(1);
        chk("t6_no_stale_write", dac_ddata, beat(800));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
